// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for a universal shift register (hold/shl/shr/load).
// Latency: LOAD/CLEAR keep busy for 2 cycles; SHL/SHR by N keep busy for N+1 cycles; done pulses in the last busy cycle.
// Backpressure: cmd_ready is high only in IDLE; a command offered while busy is dropped, not queued.
//
// Ports: clk; reset (async, active-low); cmd_valid/cmd_ready handshake carrying cmd_op, cmd_cnt,
//   cmd_fill and cmd_data; sin external serial fill; sr_o register contents in; sr_sel, sr_r and
//   sr_i drive the register (which captures on the falling edge); busy and done report status.
// Build option: define SHSEQ_SIN_EN so that fill 11 takes sin; without it, fill 11 shifts in zeros.
module shift_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [$clog2(WIDTH)-1:0]  cmd_cnt,
   input  logic [1:0]                cmd_fill,
   input  logic [WIDTH-1:0]          cmd_data,
   input  logic                      sin,
   input  logic [WIDTH-1:0]          sr_o,
   output logic [1:0]                sr_sel,
   output logic                      sr_r,
   output logic [WIDTH-1:0]          sr_i,
   output logic                      busy,
   output logic                      done
);

   localparam int CW = $clog2(WIDTH);
   // One extra bit so a count of 0 can be stored as a full WIDTH shifts.
   localparam int RW = CW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_SHL   = 2'd1;
   localparam logic [1:0] OP_SHR   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [1:0] FILL_ONE = 2'd1;
   localparam logic [1:0] FILL_ROT = 2'd2;
   localparam logic [1:0] FILL_SIN = 2'd3;

   logic [1:0]       state;
   logic [1:0]       op_q;
   logic [1:0]       fill_q;
   logic [WIDTH-1:0] data_q;
   logic [RW-1:0]    rem_q;
   logic             accept;
   logic             sin_fill;
   logic             unused_sr_o;

`ifdef SHSEQ_SIN_EN
   assign sin_fill = sin;
`else
   logic unused_sin;
   assign unused_sin = sin;
   assign sin_fill   = 1'b0;
`endif

   // Only the end bits of sr_o feed the rotate path; the rest are deliberately unused.
   assign unused_sr_o = ^sr_o;

   assign accept = cmd_valid && (state == ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         op_q   <= OP_LOAD;
         fill_q <= 2'b00;
         data_q <= '0;
         rem_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= cmd_op;
                  fill_q <= cmd_fill;
                  // CLEAR is a load of zero, so it shares the LOAD state.
                  data_q <= (cmd_op == OP_CLEAR) ? '0 : cmd_data;
                  rem_q  <= (cmd_cnt == '0) ? RW'(WIDTH) : RW'(cmd_cnt);
                  state  <= (cmd_op == OP_SHL || cmd_op == OP_SHR) ? ST_SHIFT : ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_DONE;
            end
            ST_SHIFT: begin
               rem_q <= rem_q - 1'b1;
               if (rem_q == RW'(1)) begin
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // All outputs decode from state so reset forces them to their idle values immediately.
   always_comb begin
      cmd_ready = (state == ST_IDLE);
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      sr_sel    = 2'b00;
      sr_r      = 1'b0;
      sr_i      = '0;
      case (state)
         ST_LOAD: begin
            sr_sel = 2'b11;
            sr_i   = data_q;
         end
         ST_SHIFT: begin
            sr_sel = (op_q == OP_SHL) ? 2'b01 : 2'b10;
            // Rotate feeds back the bit that is about to fall off the far end.
            case (fill_q)
               FILL_ONE: sr_r = 1'b1;
               FILL_ROT: sr_r = (op_q == OP_SHL) ? sr_o[WIDTH-1] : sr_o[0];
               FILL_SIN: sr_r = sin_fill;
               default:  sr_r = 1'b0;
            endcase
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller for the 8-bit universal shift register (hold / shift-left / shift-right / parallel-load datapath). It accepts one command at a time over a valid/ready handshake and drives the register's 2-bit mode select, serial fill bit and parallel data. It then steps the register for the commanded number of clocks and pulses `done`. It sits between a host FSM or test harness and the shift register instance. The shift register's own reset is wired separately.

## Interface
- `WIDTH`, 8, shift register width; `cmd_cnt` width is clog2(WIDTH).
- `clk`  in  1  clock; the controller updates on rising edge, the shift register captures on falling edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  operation: 00 LOAD, 01 SHL (toward MSB), 10 SHR (toward LSB), 11 CLEAR.
- `cmd_cnt`  in  clog2(WIDTH)  shift count for SHL/SHR; 0 means WIDTH. Ignored for LOAD/CLEAR.
- `cmd_fill`  in  2  fill bit source: 00 zero, 01 one, 10 rotate, 11 external `sin`.
- `cmd_data`  in  WIDTH  parallel data for LOAD.
- `sin`  in  1  external serial input.
- `sr_o`  in  WIDTH  shift register current contents.
- `sr_sel`  out  2  register mode: 00 hold, 01 shift-left (o[0]<=r), 10 shift-right (o[MSB]<=r), 11 load.
- `sr_r`  out  1  serial fill bit to the register.
- `sr_i`  out  WIDTH  parallel load data to the register.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `cmd_ready`=1 and `sr_sel`=00. On the rising edge with `cmd_valid`&`cmd_ready`, the controller latches op, cnt, fill and data.
  - LOAD goes to LOAD with `sr_i`=data.
  - CLEAR goes to LOAD with `sr_i`=0.
  - SHL/SHR go to SHIFT with remaining = cnt (0 becomes WIDTH).
- LOAD: `sr_sel`=11 for exactly one cycle, then DONE.
- SHIFT: `sr_sel`=01 (SHL) or 10 (SHR) every cycle. Remaining decrements on each rising edge; on the edge where remaining=1, go to DONE.
- DONE: `sr_sel`=00, `done`=1, `cmd_ready`=0, then IDLE.
- `busy`=1 in LOAD, SHIFT and DONE.
- `sr_r` is combinational and valid only in SHIFT (0 elsewhere):
  - fill 00 gives 0; fill 01 gives 1.
  - fill 10 gives `sr_o[WIDTH-1]` for SHL and `sr_o[0]` for SHR.
  - fill 11 gives `sin`.
- `sr_i` holds the latched load value through LOAD; otherwise it is 0.
- Commands presented while not ready are ignored, not queued. `cmd_*` is sampled only at acceptance.

## Timing
- Reset (low, asynchronous) forces IDLE and all outputs to these values: `cmd_ready`=1, `busy`=0, `done`=0, `sr_sel`=00, `sr_r`=0, `sr_i`=0. This holds even mid-command, so the register holds its partial result.
- Accept at rising edge E0:
  - The first operation cycle spans E0..E1, and the register captures at the falling edge inside it (half-cycle setup).
  - LOAD/CLEAR: `done` is high during E1..E2; `cmd_ready` returns at E2. Next accept is at E2, giving 2 cycles per command.
  - SHL/SHR with count N: `sr_sel` is active for N cycles, `done` is high in cycle N+1, next accept at E(N+1).
- Rotate/sin fill must meet the falling-edge setup. `sr_o` changes at the falling edge and must settle before the next falling edge.
- `done` never coincides with `cmd_ready`=1.

## Configuration
- `SHSEQ_SIN_EN` defined: fill 11 selects `sin`.
- `SHSEQ_SIN_EN` undefined: the `sin` port remains but is ignored, and fill 11 behaves as fill 00 (zero).

## Test plan
- Reset low mid-SHIFT (e.g. cnt=5, after 2 shifts) -> next cycle `sr_sel`=00, `busy`=0, `cmd_ready`=1. The register stays at its 2-shift value.
- LOAD 8'hA5 then SHL cnt=3 fill 00 -> register 8'h28. `done` pulses once per command; total 2+4 cycles.
- LOAD 8'h81, SHR cnt=0 (8) fill 10 -> register returns to 8'h81 after 8 shifts. `sr_sel`=10 for exactly 8 cycles.
- LOAD 8'h00, SHL cnt=4 fill 11 with `sin` = 1,0,1,1 per cycle:
  - With `SHSEQ_SIN_EN` defined -> 8'h0B.
  - Without it -> 8'h00.
- `cmd_valid` held high continuously, with CLEAR then LOAD 8'h3C issued back-to-back -> the second command is accepted only when `cmd_ready`=1, two cycles after the first. Final register value is 8'h3C; `cmd_*` changes while busy have no effect.
